decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Instruction-decode stage of the 8-bit pipelined core. It sits between the IF/ID register and the ID/EX register.
- Decodes 8-bit instructions, including the 2-byte LDM.
- Drives the register-file read addresses and stack-pointer inc/dec strobes.
- Captures operands and control into the ID/EX register.
- Inserts load-use bubbles.
- Handles downstream stall and branch flush.

Parameters:
WIDTH, 8, data and instruction width
ADDR, 2, register address width (4 GPRs)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
if_instr  in  WIDTH  instruction byte from IF/ID
if_valid  in  1  if_instr is valid
if_ready  out  1  stage accepts if_instr this cycle
stall_in  in  1  downstream hold; freeze the ID/EX register
flush  in  1  taken branch from EX; kill the in-flight decode
rd_addr_a  out  ADDR  register-file read address A (= instr[3:2])
rd_addr_b  out  ADDR  register-file read address B (= instr[1:0])
reg_a_data  in  WIDTH  register-file read data A
reg_b_data  in  WIDTH  register-file read data B
sp_val  in  WIDTH  stack pointer from register file
sp_inc_en  out  1  SP increment strobe (POP)
sp_dec_en  out  1  SP decrement strobe (PUSH)
ex_valid  out  1  ID/EX holds a real instruction
ex_alu_op  out  4  ALU operation code
ex_op_a  out  WIDTH  operand A / memory address
ex_op_b  out  WIDTH  operand B / store data / immediate
ex_dst  out  ADDR  writeback register
ex_reg_we  out  1  writeback enable
ex_mem_rd  out  1  memory read (LD, POP)
ex_mem_wr  out  1  memory write (ST, PUSH)
ex_jump  out  1  JMP; target in ex_op_b

Behaviour:
Encoding: opcode = instr[7:4], ra = instr[3:2], rb = instr[1:0].

Opcodes:
- 0 NOP
- 1 ADD, 2 SUB, 3 AND, 4 OR: ra <= ra op rb
- 5 MOV: ra <= rb
- 6 NOT: ra <= ~rb
- 7 INC: ra <= ra + 1
- 8 DEC: ra <= ra - 1
- 9 LDM: ra <= next byte
- A LD: ra <= M[rb]
- B ST: M[ra] <= rb
- C PUSH rb
- D POP ra
- E JMP rb
- F reserved; decodes as NOP with ex_valid = 1 and all enables 0.

Read addresses:
- rd_addr_a and rd_addr_b are combinational from if_instr in state DECODE.
- Register-file data is sampled in the same cycle.

State machine:
- Reset state is DECODE.
- DECODE -> IMM on accepting LDM. The ra field is latched internally; nothing is written to ID/EX.
- IMM -> DECODE on accepting the next byte. That byte goes to ex_op_b with ex_dst = latched ra, ex_reg_we = 1, ex_alu_op = PASS_B.
- In IMM, if_valid low holds the state.

Handshake:
- if_ready = !stall_in && !hazard && !flush.
- An instruction is accepted when if_valid && if_ready.
- Latency: accept at cycle N, ex_* valid at N+1. For LDM, the second byte is accepted at N+1 and appears on ex_* at N+2.
- No accept with no stall: ID/EX loads a bubble (ex_valid = 0, all enables 0).

Stack pointer:
- sp_dec_en (PUSH) and sp_inc_en (POP) are combinational and asserted only in the accept cycle. This gives exactly one pulse per instruction, never during stall, hazard or flush.
- PUSH: ex_op_a = sp_val sampled before decrement, ex_op_b = reg_b_data, ex_mem_wr = 1.
- POP: ex_op_a = sp_val sampled after increment, ex_mem_rd = 1, ex_dst = ra, ex_reg_we = 1.

Load-use hazard:
- Condition: ex_valid && ex_mem_rd && ex_reg_we && ex_dst matches a source register used by the current instruction.
- Sources used: ra for ADD/SUB/AND/OR/INC/DEC/ST; rb for ADD/SUB/AND/OR/MOV/NOT/LD/ST/PUSH/JMP.
- Response: exactly one bubble, then accept.
- The hazard is never evaluated on the LDM immediate byte.

Priority (highest first): rst_n low > flush > stall_in > hazard > accept.
- flush: ex_valid <= 0, state <= DECODE, any partial LDM is discarded, no SP strobe.
- stall_in: all ID/EX outputs hold their values; state holds.

Reset:
- Applies asynchronously, whether mid-LDM or mid-stall.
- All ex_* outputs go to 0 and state goes to DECODE.
- sp_*_en = 0 and if_ready = 0 while rst_n is low.
- if_ready = 1 from the first cycle after release.

Arithmetic: performed in EX; INC/DEC pass reg_a_data as operand A with an implicit 1 as operand B, and wrap modulo 2^WIDTH.

Decomposition:
- cpu_pkg holds:
  - opcode_e: 4-bit enum of the 16 opcodes.
  - alu_op_e: ADD, SUB, AND, OR, PASS_B, NOT_B, INC, DEC.
  - dec_state_e: DECODE, IMM.
  - id_ex_t: packed struct of all ex_* fields.
- One sub-module, hazard_unit: combinational; compares ex_dst, ex_mem_rd and ex_valid against the used-source mask from the decoder and produces hazard.

Test Plan:
- Sequence ADD r1,r2 (0x16) with reg_a = 0x05, reg_b = 0x03 -> next cycle ex_alu_op = ADD, ex_op_a = 0x05, ex_op_b = 0x03, ex_dst = 1, ex_reg_we = 1.
- Send LDM r2 (0x98), then 0x7F -> no ex_valid after byte 1; after byte 2, ex_dst = 2, ex_op_b = 0x7F. Assert flush between the bytes -> state returns to DECODE and the next byte decodes as an opcode.
- LD r1,[r0] (0xA4) followed by ADD r0,r1 (0x11) -> exactly one bubble with if_ready = 0 for one cycle, then ADD issues.
- PUSH r3 (0xC3) with sp_val = 0x80 held under stall_in for 3 cycles -> sp_dec_en pulses once in the accept cycle only, ex_op_a = 0x80, ex_mem_wr = 1.
- Assert rst_n low mid-IMM, combined with stall_in = 1 -> all ex_* outputs go to 0 immediately; after release, opcode 0xF0 decodes as NOP with ex_valid = 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit core: opcodes, ALU operations, decode states
// and the ID/EX pipeline record.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int REG_W  = 2;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_MOV  = 4'h5,
    OP_NOT  = 4'h6,
    OP_INC  = 4'h7,
    OP_DEC  = 4'h8,
    OP_LDM  = 4'h9,
    OP_LD   = 4'hA,
    OP_ST   = 4'hB,
    OP_PUSH = 4'hC,
    OP_POP  = 4'hD,
    OP_JMP  = 4'hE,
    OP_RSVD = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_PASS_B = 4'd4,
    ALU_NOT_B  = 4'd5,
    ALU_INC    = 4'd6,
    ALU_DEC    = 4'd7
  } alu_op_e;

  typedef enum logic {
    DECODE = 1'b0,
    IMM    = 1'b1
  } dec_state_e;

  typedef struct packed {
    logic              valid;
    alu_op_e           alu_op;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [REG_W-1:0]  dst;
    logic              reg_we;
    logic              mem_rd;
    logic              mem_wr;
    logic              jump;
  } id_ex_t;

  // Returns {reads_ra, reads_rb} for the load-use comparison.
  function automatic logic [1:0] src_mask(opcode_e op);
    logic [1:0] m;
    m = 2'b00;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ST:  m = 2'b11;
      OP_INC, OP_DEC:                        m = 2'b10;
      OP_MOV, OP_NOT, OP_LD, OP_PUSH, OP_JMP: m = 2'b01;
      default:                               m = 2'b00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/decode_stage_hazard_unit.sv
// Load-use detector: flags when the load sitting in ID/EX writes a register
// the instruction now in decode wants to read.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int ADDR = 2
) (
  input  logic            ex_valid,
  input  logic            ex_mem_rd,
  input  logic            ex_reg_we,
  input  logic [ADDR-1:0] ex_dst,
  input  logic [ADDR-1:0] ra,
  input  logic [ADDR-1:0] rb,
  input  logic            use_ra,
  input  logic            use_rb,
  output logic            hazard
);

  logic load_in_ex;
  logic match_a;
  logic match_b;

  assign load_in_ex = ex_valid && ex_mem_rd && ex_reg_we;
  assign match_a    = use_ra && (ex_dst == ra);
  assign match_b    = use_rb && (ex_dst == rb);
  assign hazard     = load_in_ex && (match_a || match_b);

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes one byte per cycle (two for LDM), drives
// register-file reads and SP strobes, and fills the ID/EX register.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ADDR  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] if_instr,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic             stall_in,
  input  logic             flush,
  output logic [ADDR-1:0]  rd_addr_a,
  output logic [ADDR-1:0]  rd_addr_b,
  input  logic [WIDTH-1:0] reg_a_data,
  input  logic [WIDTH-1:0] reg_b_data,
  input  logic [WIDTH-1:0] sp_val,
  output logic             sp_inc_en,
  output logic             sp_dec_en,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_op,
  output logic [WIDTH-1:0] ex_op_a,
  output logic [WIDTH-1:0] ex_op_b,
  output logic [ADDR-1:0]  ex_dst,
  output logic             ex_reg_we,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic             ex_jump
);

  dec_state_e      state_q, state_d;
  logic [ADDR-1:0] imm_dst_q, imm_dst_d;
  id_ex_t          id_ex_q, id_ex_d;
  id_ex_t          decoded;

  opcode_e         opcode;
  logic [ADDR-1:0] ra;
  logic [ADDR-1:0] rb;
  logic            in_decode;
  logic [1:0]      src_used;
  logic            hazard;
  logic            accept;

  assign opcode    = opcode_e'(if_instr[WIDTH-1 -: 4]);
  assign ra        = if_instr[2*ADDR-1 -: ADDR];
  assign rb        = if_instr[ADDR-1:0];
  assign rd_addr_a = ra;
  assign rd_addr_b = rb;
  assign in_decode = (state_q == DECODE);

  // The LDM immediate byte is data, so it never contributes source registers.
  assign src_used = (in_decode && if_valid) ? src_mask(opcode) : 2'b00;

  hazard_unit #(
    .ADDR (ADDR)
  ) u_hazard (
    .ex_valid  (id_ex_q.valid),
    .ex_mem_rd (id_ex_q.mem_rd),
    .ex_reg_we (id_ex_q.reg_we),
    .ex_dst    (id_ex_q.dst),
    .ra        (ra),
    .rb        (rb),
    .use_ra    (src_used[1]),
    .use_rb    (src_used[0]),
    .hazard    (hazard)
  );

  assign if_ready  = rst_n && !stall_in && !hazard && !flush;
  assign accept    = if_valid && if_ready;
  assign sp_dec_en = accept && in_decode && (opcode == OP_PUSH);
  assign sp_inc_en = accept && in_decode && (opcode == OP_POP);

  always_comb begin
    decoded       = '0;
    decoded.valid = 1'b1;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_NOT: begin
        decoded.op_a   = reg_a_data;
        decoded.op_b   = reg_b_data;
        decoded.dst    = ra;
        decoded.reg_we = 1'b1;
        case (opcode)
          OP_ADD:  decoded.alu_op = ALU_ADD;
          OP_SUB:  decoded.alu_op = ALU_SUB;
          OP_AND:  decoded.alu_op = ALU_AND;
          OP_OR:   decoded.alu_op = ALU_OR;
          OP_MOV:  decoded.alu_op = ALU_PASS_B;
          default: decoded.alu_op = ALU_NOT_B;
        endcase
      end
      OP_INC, OP_DEC: begin
        decoded.alu_op = (opcode == OP_INC) ? ALU_INC : ALU_DEC;
        decoded.op_a   = reg_a_data;
        decoded.op_b   = WIDTH'(1);
        decoded.dst    = ra;
        decoded.reg_we = 1'b1;
      end
      OP_LD: begin
        decoded.alu_op = ALU_PASS_B;
        decoded.op_a   = reg_b_data;
        decoded.dst    = ra;
        decoded.reg_we = 1'b1;
        decoded.mem_rd = 1'b1;
      end
      OP_ST: begin
        decoded.alu_op = ALU_PASS_B;
        decoded.op_a   = reg_a_data;
        decoded.op_b   = reg_b_data;
        decoded.mem_wr = 1'b1;
      end
      OP_PUSH: begin
        decoded.alu_op = ALU_PASS_B;
        decoded.op_a   = sp_val;
        decoded.op_b   = reg_b_data;
        decoded.mem_wr = 1'b1;
      end
      OP_POP: begin
        // The SP strobe lands on this edge, so the pop address is SP + 1.
        decoded.alu_op = ALU_PASS_B;
        decoded.op_a   = sp_val + WIDTH'(1);
        decoded.dst    = ra;
        decoded.reg_we = 1'b1;
        decoded.mem_rd = 1'b1;
      end
      OP_JMP: begin
        decoded.alu_op = ALU_PASS_B;
        decoded.op_b   = reg_b_data;
        decoded.jump   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    imm_dst_d = imm_dst_q;
    id_ex_d   = id_ex_q;
    if (flush) begin
      state_d = DECODE;
      id_ex_d = '0;
    end else if (stall_in) begin
      id_ex_d = id_ex_q;
    end else if (accept) begin
      if (!in_decode) begin
        id_ex_d        = '0;
        id_ex_d.valid  = 1'b1;
        id_ex_d.alu_op = ALU_PASS_B;
        id_ex_d.op_b   = if_instr;
        id_ex_d.dst    = imm_dst_q;
        id_ex_d.reg_we = 1'b1;
        state_d        = DECODE;
      end else if (opcode == OP_LDM) begin
        id_ex_d   = '0;
        imm_dst_d = ra;
        state_d   = IMM;
      end else begin
        id_ex_d = decoded;
      end
    end else begin
      id_ex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DECODE;
      imm_dst_q <= '0;
      id_ex_q   <= '0;
    end else begin
      state_q   <= state_d;
      imm_dst_q <= imm_dst_d;
      id_ex_q   <= id_ex_d;
    end
  end

  assign ex_valid  = id_ex_q.valid;
  assign ex_alu_op = id_ex_q.alu_op;
  assign ex_op_a   = id_ex_q.op_a;
  assign ex_op_b   = id_ex_q.op_b;
  assign ex_dst    = id_ex_q.dst;
  assign ex_reg_we = id_ex_q.reg_we;
  assign ex_mem_rd = id_ex_q.mem_rd;
  assign ex_mem_wr = id_ex_q.mem_wr;
  assign ex_jump   = id_ex_q.jump;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized stream checked
// against an instruction-level model of the stage.
module tb_decode_stage;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] if_instr;
  logic       if_valid;
  logic       if_ready;
  logic       stall_in;
  logic       flush;
  logic [1:0] rd_addr_a, rd_addr_b;
  logic [7:0] reg_a_data, reg_b_data, sp_val;
  logic       sp_inc_en, sp_dec_en;
  logic       ex_valid;
  logic [3:0] ex_alu_op;
  logic [7:0] ex_op_a, ex_op_b;
  logic [1:0] ex_dst;
  logic       ex_reg_we, ex_mem_rd, ex_mem_wr, ex_jump;

  logic [7:0] regs [4];

  decode_stage #(.WIDTH(8), .ADDR(2)) dut (
    .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_valid(if_valid),
    .if_ready(if_ready), .stall_in(stall_in), .flush(flush),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .reg_a_data(reg_a_data), .reg_b_data(reg_b_data), .sp_val(sp_val),
    .sp_inc_en(sp_inc_en), .sp_dec_en(sp_dec_en), .ex_valid(ex_valid),
    .ex_alu_op(ex_alu_op), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_dst(ex_dst), .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_jump(ex_jump)
  );

  always #5 clk = ~clk;

  assign reg_a_data = regs[if_instr[3:2]];
  assign reg_b_data = regs[if_instr[1:0]];

  typedef struct packed {
    logic       valid;
    logic [3:0] alu;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] dst;
    logic       we;
    logic       rd;
    logic       wr;
    logic       jmp;
  } exp_t;

  exp_t act;
  assign act = {ex_valid, ex_alu_op, ex_op_a, ex_op_b, ex_dst,
                ex_reg_we, ex_mem_rd, ex_mem_wr, ex_jump};

  int checks = 0;
  int errors = 0;
  int dec_pulses = 0;

  always @(posedge clk) if (sp_dec_en) dec_pulses <= dec_pulses + 1;

  // Model state: what ID/EX should hold, and whether an LDM byte is pending.
  exp_t       m_ex, m_next;
  bit         m_imm, m_next_imm;
  logic [1:0] m_imm_dst, m_next_dst;
  bit         e_ready, e_inc, e_dec, e_acc;

  function automatic bit reads_ra(logic [3:0] op);
    return op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'hB};
  endfunction

  function automatic bit reads_rb(logic [3:0] op);
    return op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB, 4'hC, 4'hE};
  endfunction

  // What each instruction means for the EX stage, written as field tables.
  function automatic exp_t semantics(logic [7:0] ins, logic [7:0] a, logic [7:0] b,
                                     logic [7:0] sp);
    exp_t       r;
    logic [3:0] op;
    bit         writes;
    op     = ins[7:4];
    r      = '0;
    r.valid = 1'b1;
    writes = op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hD};
    r.we   = writes;
    r.dst  = writes ? ins[3:2] : 2'd0;
    r.rd   = op inside {4'hA, 4'hD};
    r.wr   = op inside {4'hB, 4'hC};
    r.jmp  = (op == 4'hE);
    case (op)
      4'h1: r.alu = ALU_ADD;
      4'h2: r.alu = ALU_SUB;
      4'h3: r.alu = ALU_AND;
      4'h4: r.alu = ALU_OR;
      4'h5, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: r.alu = ALU_PASS_B;
      4'h6: r.alu = ALU_NOT_B;
      4'h7: r.alu = ALU_INC;
      4'h8: r.alu = ALU_DEC;
      default: r.alu = 4'd0;
    endcase
    if (op >= 4'h1 && op <= 4'h8) r.a = a;
    else if (op == 4'hA) r.a = b;
    else if (op == 4'hB) r.a = a;
    else if (op == 4'hC) r.a = sp;
    else if (op == 4'hD) r.a = sp + 8'd1;
    if (op >= 4'h1 && op <= 4'h6) r.b = b;
    else if (op == 4'h7 || op == 4'h8) r.b = 8'd1;
    else if (op inside {4'hB, 4'hC, 4'hE}) r.b = b;
    return r;
  endfunction

  task automatic model_clear();
    m_ex = '0; m_imm = 0; m_imm_dst = 2'd0;
  endtask

  // Drive one cycle's inputs on the falling edge and predict this cycle.
  task automatic apply(bit v, logic [7:0] ins, bit s, bit f);
    logic [3:0] op;
    bit         hz;
    @(negedge clk);
    if_valid = v; if_instr = ins; stall_in = s; flush = f;
    #1;
    op = ins[7:4];
    hz = !m_imm && v && m_ex.valid && m_ex.rd && m_ex.we &&
         ((reads_ra(op) && m_ex.dst == ins[3:2]) || (reads_rb(op) && m_ex.dst == ins[1:0]));
    e_ready = !s && !f && !hz;
    e_acc   = v && e_ready;
    e_dec   = e_acc && !m_imm && op == 4'hC;
    e_inc   = e_acc && !m_imm && op == 4'hD;
    m_next     = m_ex;
    m_next_imm = m_imm;
    m_next_dst = m_imm_dst;
    if (f) begin
      m_next = '0; m_next_imm = 0;
    end else if (s) begin
      m_next = m_ex;
    end else if (e_acc) begin
      if (m_imm) begin
        m_next = '0; m_next.valid = 1; m_next.alu = ALU_PASS_B;
        m_next.b = ins; m_next.dst = m_imm_dst; m_next.we = 1;
        m_next_imm = 0;
      end else if (op == 4'h9) begin
        m_next = '0; m_next_imm = 1; m_next_dst = ins[3:2];
      end else begin
        m_next = semantics(ins, regs[ins[3:2]], regs[ins[1:0]], sp_val);
      end
    end else begin
      m_next = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_ex = m_next; m_imm = m_next_imm; m_imm_dst = m_next_dst;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1; if_valid = 1; if_instr = 8'hC3; stall_in = 0; flush = 0;
    sp_val = 8'h10;
    for (int i = 0; i < 4; i++) regs[i] = 8'h11 * i[7:0];
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (act !== '0) begin errors++; $display("FAIL reset_ex: got %h want 0", act); end
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", if_ready); end
    checks++; if (sp_dec_en !== 1'b0) begin errors++; $display("FAIL reset_spdec: got %b want 0", sp_dec_en); end
    @(negedge clk);
    if_valid = 0; rst_n = 1;
    #1;
    model_clear();
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", if_ready); end
    $display("reset released, if_ready=%b", if_ready);
    // Async reset with a live instruction in ID/EX.
    apply(1, 8'h16, 0, 0);
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL pre_async_valid: got %b want 1", ex_valid); end
    #2 rst_n = 0;
    #1;
    checks++; if (act !== '0) begin errors++; $display("FAIL async_reset_ex: got %h want 0", act); end
    @(negedge clk);
    rst_n = 1; if_valid = 0;
    model_clear();
    $display("async reset cleared ex=%h", act);
  endtask

  task automatic test_alu();
    regs[1] = 8'h05; regs[2] = 8'h03;
    apply(1, 8'h16, 0, 0);
    checks++; if (rd_addr_a !== 2'd1 || rd_addr_b !== 2'd2) begin
      errors++; $display("FAIL add_rdaddr: got %0d/%0d want 1/2", rd_addr_a, rd_addr_b); end
    tick();
    checks++; if (ex_alu_op !== 4'd0 || ex_op_a !== 8'h05 || ex_op_b !== 8'h03 ||
                  ex_dst !== 2'd1 || ex_reg_we !== 1'b1 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL add_issue: got %h want alu0 a05 b03 dst1 we1", act); end
    checks++; if (act !== m_ex) begin errors++; $display("FAIL add_model: got %h want %h", act, m_ex); end
    $display("ADD r1,r2 -> ex=%h", act);
    regs[3] = 8'hFF;
    apply(1, 8'h7C, 0, 0);
    tick();
    checks++; if (ex_alu_op !== 4'(ALU_INC) || ex_op_a !== 8'hFF || ex_op_b !== 8'h01 || ex_dst !== 2'd3) begin
      errors++; $display("FAIL inc_issue: got %h want INC aFF b01 dst3", act); end
    $display("INC r3 -> ex=%h", act);
  endtask

  task automatic test_ldm();
    apply(1, 8'h98, 0, 0);
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL ldm_byte1_valid: got %b want 0", ex_valid); end
    apply(1, 8'h7F, 0, 0);
    checks++; if (if_ready !== 1'b1 || sp_inc_en !== 1'b0) begin
      errors++; $display("FAIL ldm_byte2_ready: got rdy %b inc %b want 1 0", if_ready, sp_inc_en); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_dst !== 2'd2 || ex_op_b !== 8'h7F ||
                  ex_reg_we !== 1'b1 || ex_alu_op !== 4'(ALU_PASS_B)) begin
      errors++; $display("FAIL ldm_issue: got %h want PASS_B b7F dst2 we1", act); end
    $display("LDM r2,0x7F -> ex=%h", act);
    // IMM waits while the immediate byte is not yet valid.
    apply(1, 8'h98, 0, 0); tick();
    apply(0, 8'hA5, 0, 0); tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL ldm_hold_valid: got %b want 0", ex_valid); end
    apply(1, 8'h55, 0, 0); tick();
    checks++; if (ex_op_b !== 8'h55 || ex_dst !== 2'd2 || ex_alu_op !== 4'(ALU_PASS_B)) begin
      errors++; $display("FAIL ldm_hold_issue: got %h want b55 dst2", act); end
    // Flush between the two bytes drops the LDM.
    apply(1, 8'h98, 0, 0); tick();
    apply(1, 8'h7F, 0, 1);
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", if_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", ex_valid); end
    apply(1, 8'h16, 0, 0); tick();
    checks++; if (ex_alu_op !== 4'(ALU_ADD) || ex_dst !== 2'd1 || ex_valid !== 1'b1 || act !== m_ex) begin
      errors++; $display("FAIL flush_redecode: got %h want %h", act, m_ex); end
    $display("LDM flushed, next byte -> ex=%h", act);
  endtask

  task automatic test_load_use();
    regs[0] = 8'h40; regs[1] = 8'h09;
    apply(1, 8'hA4, 0, 0); tick();
    checks++; if (ex_mem_rd !== 1'b1 || ex_dst !== 2'd1 || ex_op_a !== 8'h40) begin
      errors++; $display("FAIL ld_issue: got %h want rd1 dst1 a40", act); end
    apply(1, 8'h11, 0, 0);
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL hazard_ready: got %b want 0", if_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL hazard_bubble: got %b want 0", ex_valid); end
    apply(1, 8'h11, 0, 0);
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL hazard_release: got %b want 1", if_ready); end
    tick();
    checks++; if (ex_alu_op !== 4'(ALU_ADD) || ex_dst !== 2'd0 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL hazard_add: got %h want ADD dst0", act); end
    $display("LD r1 / ADD r0,r1 -> one bubble, ex=%h", act);
    // INC reads only ra, so rb == load dst must not stall.
    apply(1, 8'hA4, 0, 0); tick();
    apply(1, 8'h71, 0, 0);
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL nohazard_inc: got %b want 1", if_ready); end
    tick();
  endtask

  task automatic test_push_stall();
    int base;
    sp_val = 8'h80; regs[3] = 8'h3C;
    base = dec_pulses;
    for (int i = 0; i < 3; i++) begin
      apply(1, 8'hC3, 1, 0);
      checks++; if (sp_dec_en !== 1'b0 || if_ready !== 1'b0) begin
        errors++; $display("FAIL push_stalled %0d: got dec %b rdy %b want 0 0", i, sp_dec_en, if_ready); end
      tick();
    end
    apply(1, 8'hC3, 0, 0);
    checks++; if (sp_dec_en !== 1'b1) begin errors++; $display("FAIL push_strobe: got %b want 1", sp_dec_en); end
    tick();
    sp_val = 8'h7F;
    for (int i = 0; i < 3; i++) begin
      apply(1, 8'h00, 1, 0); tick();
      checks++; if (ex_op_a !== 8'h80 || ex_op_b !== 8'h3C || ex_mem_wr !== 1'b1 || ex_valid !== 1'b1) begin
        errors++; $display("FAIL push_hold %0d: got %h want a80 b3C wr1", i, act); end
    end
    checks++; if (dec_pulses - base !== 1) begin
      errors++; $display("FAIL push_pulses: got %0d want 1", dec_pulses - base); end
    $display("PUSH r3 sp=80 -> ex=%h pulses=%0d", act, dec_pulses - base);
  endtask

  task automatic test_reset_mid_imm();
    apply(1, 8'h98, 0, 0); tick();
    apply(1, 8'hC3, 1, 0);
    #2 rst_n = 0;
    #1;
    checks++; if (act !== '0 || if_ready !== 1'b0 || sp_dec_en !== 1'b0) begin
      errors++; $display("FAIL imm_reset: got ex %h rdy %b dec %b want 0", act, if_ready, sp_dec_en); end
    @(negedge clk);
    rst_n = 1; stall_in = 0; if_valid = 0;
    model_clear();
    apply(1, 8'hF0, 0, 0); tick();
    checks++; if (ex_valid !== 1'b1 || ex_reg_we !== 1'b0 || ex_mem_rd !== 1'b0 ||
                  ex_mem_wr !== 1'b0 || ex_jump !== 1'b0) begin
      errors++; $display("FAIL rsvd_nop: got %h want valid with no enables", act); end
    $display("reset mid-IMM, then 0xF0 -> ex=%h", act);
  endtask

  task automatic test_random();
    logic [7:0] ins;
    bit v, s, f;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) regs[i] = 8'($urandom);
      sp_val = 8'($urandom);
      v = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 9) < 3) ins = {($urandom_range(0, 1) == 0) ? 4'hA : 4'hD, 4'($urandom)};
      else ins = 8'($urandom);
      s = ($urandom_range(0, 9) < 2);
      f = ($urandom_range(0, 11) == 0);
      apply(v, ins, s, f);
      checks++; if (if_ready !== e_ready) begin
        errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, if_ready, e_ready); end
      checks++; if (sp_inc_en !== e_inc || sp_dec_en !== e_dec) begin
        errors++; $display("FAIL rnd_sp c%0d: got inc %b dec %b want %b %b", c, sp_inc_en, sp_dec_en, e_inc, e_dec); end
      if (!m_imm) begin
        checks++; if (rd_addr_a !== ins[3:2] || rd_addr_b !== ins[1:0]) begin
          errors++; $display("FAIL rnd_rdaddr c%0d: got %0d/%0d want %0d/%0d", c, rd_addr_a, rd_addr_b, ins[3:2], ins[1:0]); end
      end
      if (e_acc) $display("rnd %0d: accept %02h%s", c, ins, m_imm ? " (imm)" : "");
      tick();
      checks++; if (act !== m_ex) begin
        errors++; $display("FAIL rnd_ex c%0d: got %h want %h", c, act, m_ex); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ldm();
    test_load_use();
    test_push_stall();
    test_reset_mid_imm();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
